// File: rtl/demod_pkg.sv
// Shared demodulator constants and the symbol-controller state set.
package demod_pkg;

    localparam int SYMBOL_LEN = 32;
    localparam int CORR_W     = 24;
    localparam int PIPE_LAT   = 5;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        SEARCH,
        TRACK
    } state_t;

endpackage

// File: rtl/corr_mag.sv
// Correlation metric: max(|sin-bias|, |cos-bias|), plus the sine sign.
module corr_mag #(
    parameter int W = 24
) (
    input  logic [W-1:0] sin_corr,
    input  logic [W-1:0] cos_corr,
    input  logic [W-1:0] bias,
    output logic [W-1:0] mag,
    output logic         sin_neg
);

    logic [W:0] s;
    logic [W:0] c;
    logic [W:0] abs_s;
    logic [W:0] abs_c;
    logic [W:0] mx;

    always_comb begin
        s     = {1'b0, sin_corr} - {1'b0, bias};
        c     = {1'b0, cos_corr} - {1'b0, bias};
        abs_s = s[W] ? (~s + 1'b1) : s;
        abs_c = c[W] ? (~c + 1'b1) : c;
        mx    = (abs_s > abs_c) ? abs_s : abs_c;
        mag   = mx[W] ? '1 : mx[W-1:0];
        sin_neg = s[W];
    end

endmodule

// File: rtl/demod_symbol_ctrl.sv
// Symbol timing controller: fill, peak-phase search, then tracked
// bit decisions with lock-loss detection.
module demod_symbol_ctrl
    import demod_pkg::*;
#(
    parameter int SYMBOL_LEN  = demod_pkg::SYMBOL_LEN,
    parameter int CORR_W      = demod_pkg::CORR_W,
    parameter int PIPE_LAT    = demod_pkg::PIPE_LAT,
    parameter logic [CORR_W-1:0] CORR_BIAS = 24'h040000,
    parameter logic [CORR_W-1:0] MIN_MAG   = 24'h002000,
    parameter int SEARCH_SYMS = 4,
    parameter int LOSS_CNT    = 8
) (
    input  logic                          clk_fast,
    input  logic                          rst,
    input  logic                          en,
    input  logic [CORR_W-1:0]             sin_corr,
    input  logic [CORR_W-1:0]             cos_corr,
    output logic                          bit_out,
    output logic                          valid,
    output logic                          locked,
    output logic [$clog2(SYMBOL_LEN)-1:0] phase_idx
);

    localparam int PH_W   = $clog2(SYMBOL_LEN);
    localparam int FILL_N = SYMBOL_LEN + PIPE_LAT;
    localparam int FILL_W = $clog2(FILL_N);
    localparam int WIN_N  = SEARCH_SYMS * SYMBOL_LEN;
    localparam int WIN_W  = $clog2(WIN_N);
    localparam int WEAK_W = $clog2(LOSS_CNT + 1);

    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(SYMBOL_LEN - 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_N - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_N - 1);
    localparam logic [WEAK_W-1:0] WEAK_LAST = WEAK_W'(LOSS_CNT - 1);

    state_t              state, state_nx;
    logic [FILL_W-1:0]   fill_cnt, fill_nx;
    logic [WIN_W-1:0]    win_cnt, win_nx;
    logic [PH_W-1:0]     ph, ph_nx, ph_wrap;
    logic [PH_W-1:0]     best_ph, best_ph_nx;
    logic [CORR_W-1:0]   best_mag, best_mag_nx;
    logic [WEAK_W-1:0]   weak_cnt, weak_nx;
    logic [PH_W-1:0]     pidx_nx;
    logic                bit_nx, valid_nx;
    logic [CORR_W-1:0]   mag;
    logic                sin_neg;
    logic                hit;
    logic [CORR_W-1:0]   win_mag;
    logic [PH_W-1:0]     win_ph;

    corr_mag #(.W(CORR_W)) u_mag (
        .sin_corr (sin_corr),
        .cos_corr (cos_corr),
        .bias     (CORR_BIAS),
        .mag      (mag),
        .sin_neg  (sin_neg)
    );

    assign locked = (state == TRACK);

    always_comb begin
        state_nx    = state;
        fill_nx     = fill_cnt;
        win_nx      = win_cnt;
        ph_nx       = ph;
        best_mag_nx = best_mag;
        best_ph_nx  = best_ph;
        weak_nx     = weak_cnt;
        pidx_nx     = phase_idx;
        bit_nx      = bit_out;
        valid_nx    = 1'b0;
        ph_wrap     = (ph == PH_LAST) ? '0 : ph + 1'b1;
        hit         = (mag > best_mag);
        // The window's final cycle still competes for the peak.
        win_mag     = hit ? mag : best_mag;
        win_ph      = hit ? ph : best_ph;
        if (!en) begin
            state_nx    = IDLE;
            fill_nx     = '0;
            win_nx      = '0;
            ph_nx       = '0;
            best_mag_nx = '0;
            best_ph_nx  = '0;
            weak_nx     = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nx = FILL;
                    fill_nx  = '0;
                end
                FILL: begin
                    if (fill_cnt == FILL_LAST) begin
                        state_nx = SEARCH;
                        ph_nx    = '0;
                        win_nx   = '0;
                    end else begin
                        fill_nx = fill_cnt + 1'b1;
                    end
                end
                SEARCH: begin
                    ph_nx = ph_wrap;
                    if (hit) begin
                        best_mag_nx = mag;
                        best_ph_nx  = ph;
                    end
                    if (win_cnt == WIN_LAST) begin
                        win_nx      = '0;
                        best_mag_nx = '0;
                        best_ph_nx  = '0;
                        if (win_mag >= MIN_MAG) begin
                            state_nx = TRACK;
                            pidx_nx  = win_ph;
                            weak_nx  = '0;
                        end
                    end else begin
                        win_nx = win_cnt + 1'b1;
                    end
                end
                TRACK: begin
                    ph_nx = ph_wrap;
                    if (ph == phase_idx) begin
                        if (mag >= MIN_MAG) begin
                            weak_nx  = '0;
                            bit_nx   = ~sin_neg;
                            valid_nx = 1'b1;
                        end else if (weak_cnt == WEAK_LAST) begin
                            state_nx    = SEARCH;
                            weak_nx     = '0;
                            win_nx      = '0;
                            best_mag_nx = '0;
                            best_ph_nx  = '0;
                        end else begin
                            weak_nx  = weak_cnt + 1'b1;
                            bit_nx   = ~sin_neg;
                            valid_nx = 1'b1;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_fast) begin
        if (rst) begin
            state     <= IDLE;
            fill_cnt  <= '0;
            win_cnt   <= '0;
            ph        <= '0;
            best_mag  <= '0;
            best_ph   <= '0;
            weak_cnt  <= '0;
            phase_idx <= '0;
            bit_out   <= 1'b0;
            valid     <= 1'b0;
        end else begin
            state     <= state_nx;
            fill_cnt  <= fill_nx;
            win_cnt   <= win_nx;
            ph        <= ph_nx;
            best_mag  <= best_mag_nx;
            best_ph   <= best_ph_nx;
            weak_cnt  <= weak_nx;
            phase_idx <= pidx_nx;
            bit_out   <= bit_nx;
            valid     <= valid_nx;
        end
    end

endmodule

// File: tb/tb_demod_symbol_ctrl.sv
// Bench for demod_symbol_ctrl: window-level model plus directed scenarios.
module tb_demod_symbol_ctrl;

    localparam int SL    = 32;
    localparam int BIAS  = 24'h040000;
    localparam int MINM  = 24'h002000;
    localparam int FILLN = 37;
    localparam int WIN   = 128;
    localparam int LOSS  = 8;

    logic        clk_fast = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [23:0] sin_corr = 24'(BIAS);
    logic [23:0] cos_corr = 24'(BIAS);
    logic        bit_out;
    logic        valid;
    logic        locked;
    logic [4:0]  phase_idx;

    always #5 clk_fast = ~clk_fast;

    demod_symbol_ctrl dut (
        .clk_fast  (clk_fast),
        .rst       (rst),
        .en        (en),
        .sin_corr  (sin_corr),
        .cos_corr  (cos_corr),
        .bit_out   (bit_out),
        .valid     (valid),
        .locked    (locked),
        .phase_idx (phase_idx)
    );

    int total = 0;
    int bad = 0;
    int pat = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 fill, 2 search, 3 track.
    int m_mode = 0, m_n = 0, m_ph = 0, m_pidx = 0, m_weak = 0;
    bit m_valid = 0, m_bit = 0;
    int win_mag[WIN];
    int win_ph[WIN];

    function automatic int magf(int s, int c);
        int a, b, r;
        a = (s < 0) ? -s : s;
        b = (c < 0) ? -c : c;
        r = (a > b) ? a : b;
        return (r > 24'hFFFFFF) ? 24'hFFFFFF : r;
    endfunction

    always @(posedge clk_fast) begin
        int mg;
        int bi;
        mg = magf(int'(sin_corr) - BIAS, int'(cos_corr) - BIAS);
        m_valid = 0;
        if (rst) begin
            m_mode = 0; m_n = 0; m_ph = 0; m_weak = 0;
            m_pidx = 0; m_bit = 0;
        end else if (!en) begin
            m_mode = 0; m_n = 0; m_ph = 0; m_weak = 0;
        end else begin
            case (m_mode)
                0: begin m_mode = 1; m_n = 0; end
                1: begin
                    m_n++;
                    if (m_n == FILLN) begin m_mode = 2; m_n = 0; m_ph = 0; end
                end
                2: begin
                    win_mag[m_n] = mg;
                    win_ph[m_n] = m_ph;
                    m_n++;
                    m_ph = (m_ph + 1) % SL;
                    if (m_n == WIN) begin
                        bi = 0;
                        for (int i = 1; i < WIN; i++)
                            if (win_mag[i] > win_mag[bi]) bi = i;
                        if (win_mag[bi] >= MINM) begin
                            m_mode = 3; m_pidx = win_ph[bi]; m_weak = 0;
                        end
                        m_n = 0;
                    end
                end
                default: begin
                    if (m_ph == m_pidx) begin
                        m_weak = (mg < MINM) ? m_weak + 1 : 0;
                        if (m_weak == LOSS) begin
                            m_mode = 2; m_n = 0; m_weak = 0;
                        end else begin
                            m_valid = 1;
                            m_bit = (int'(sin_corr) >= BIAS);
                        end
                    end
                    m_ph = (m_ph + 1) % SL;
                end
            endcase
        end
    end

    always @(negedge clk_fast) begin
        if (chk_on) begin
            chk("locked", 32'(locked), 32'(m_mode == 3));
            chk("valid", 32'(valid), 32'(m_valid));
            if (m_valid) chk("bit_out", 32'(bit_out), 32'(m_bit));
            if (m_mode == 3) chk("phase_idx", 32'(phase_idx), 32'(m_pidx));
        end
    end

    task automatic drive();
        sin_corr = 24'(BIAS);
        cos_corr = 24'(BIAS);
        if (m_mode >= 2) begin
            case (pat)
                1: if (m_ph == 13) sin_corr = 24'(BIAS + 24'h8000);
                2: if (m_ph == 13) sin_corr = 24'(BIAS - 24'h8000);
                3: if (m_ph == 7 || m_ph == 20) sin_corr = 24'(BIAS + 24'h8000);
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        @(negedge clk_fast);
        drive();
    endtask

    task automatic wait_lock(output int n);
        n = 0;
        while (!locked && n < 600) begin tick(); n++; end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin tick(); n++; end while (!valid && n < 200);
    endtask

    initial begin
        int n;
        int cnt;
        int seen_l;
        int seen_v;
        repeat (2) tick();
        chk_on = 1'b1;
        chk("rst_valid", 32'(valid), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_bit", 32'(bit_out), 0);
        chk("rst_phase", 32'(phase_idx), 0);

        rst = 1'b0; en = 1'b1; pat = 0;
        seen_l = 0; seen_v = 0;
        repeat (1 + FILLN + 3 * WIN + 5) begin
            tick();
            seen_l += int'(locked);
            seen_v += int'(valid);
        end
        chk("bias_no_lock", 32'(seen_l), 0);
        chk("bias_no_valid", 32'(seen_v), 0);

        rst = 1'b1; tick(); rst = 1'b0; pat = 1;
        wait_lock(n);
        chk("lock_latency", 32'(n), 166);
        chk("lock_phase13", 32'(phase_idx), 13);
        wait_valid(n);
        chk("first_strobe", 32'(n), 14);
        chk("first_bit", 32'(bit_out), 1);
        wait_valid(n);
        chk("strobe_period", 32'(n), 32);
        chk("second_bit", 32'(bit_out), 1);

        pat = 2;
        wait_valid(n);
        chk("neg_period", 32'(n), 32);
        chk("neg_bit", 32'(bit_out), 0);

        pat = 0; cnt = 0; n = 0;
        while (locked && n < 400) begin
            tick(); n++;
            cnt += int'(valid);
        end
        chk("weak_pulses", 32'(cnt), 7);
        chk("loss_unlock", 32'(locked), 0);

        rst = 1'b1; tick(); rst = 1'b0; pat = 3;
        wait_lock(n);
        chk("tie_latency", 32'(n), 166);
        chk("tie_phase7", 32'(phase_idx), 7);

        n = 0;
        while (!(m_mode == 3 && m_ph == 7) && n < 100) begin tick(); n++; end
        chk("sample_wait", 32'(m_mode == 3 && m_ph == 7), 1);
        en = 1'b0; tick();
        chk("endrop_valid", 32'(valid), 0);
        chk("endrop_locked", 32'(locked), 0);
        en = 1'b1;
        wait_lock(n);
        chk("relock_en", 32'(n), 166);

        wait_valid(n);
        rst = 1'b1; tick();
        chk("rst_trk_valid", 32'(valid), 0);
        chk("rst_trk_locked", 32'(locked), 0);
        rst = 1'b0;
        wait_lock(n);
        chk("relock_rst", 32'(n), 166);
        chk("relock_phase", 32'(phase_idx), 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demod_symbol_ctrl.md
DEMOD_SYMBOL_CTRL -- requirements
Module: demod_symbol_ctrl

Interface
REQ-001 The block SHALL have parameters: SYMBOL_LEN, default 32, fast-clock cycles per symbol.
REQ-002 The block SHALL have parameters: CORR_W, default 24, correlator word width.
REQ-003 The block SHALL have parameters: PIPE_LAT, default 5, correlator adder-tree latency in cycles.
REQ-004 The block SHALL have parameters: CORR_BIAS, default 24'h040000, unsigned DC offset of a correlator output.
REQ-005 The block SHALL have parameters: MIN_MAG, default 24'h002000, minimum valid correlation magnitude.
REQ-006 The block SHALL have parameters: SEARCH_SYMS, default 4, symbol periods per timing search.
REQ-007 The block SHALL have parameters: LOSS_CNT, default 8, consecutive weak decisions before lock loss.
REQ-008 clk_fast  in  1  sole clock; all logic on its rising edge.
REQ-009 rst  in  1  reset; synchronous and active-high.
REQ-010 en  in  1  demodulation enable.
REQ-011 sin_corr  in  CORR_W  unsigned sine correlation from the correlator.
REQ-012 cos_corr  in  CORR_W  unsigned cosine correlation; used for the lock metric only.
REQ-013 bit_out  out  1  decided symbol bit.
REQ-014 valid  out  1  one-cycle strobe qualifying bit_out.
REQ-015 locked  out  1  high while symbol timing is locked.
REQ-016 phase_idx  out  log2(SYMBOL_LEN)  locked sampling phase.

Function
REQ-017 The block SHALL define the signed offsets s = sin_corr - CORR_BIAS and c = cos_corr - CORR_BIAS, each CORR_W+1 bits.
REQ-018 The block SHALL define the metric m = max(|s|, |c|), CORR_W bits, saturating at all-ones.
REQ-019 States SHALL be IDLE, FILL, SEARCH and TRACK; every state SHALL go to IDLE on the next cycle when en=0.
REQ-020 IDLE: the block SHALL hold all counters at 0 and go to FILL on the first cycle with en=1.
REQ-021 FILL: the block SHALL count SYMBOL_LEN+PIPE_LAT cycles (37 by default) and then go to SEARCH with the phase counter ph=0.
REQ-022 The phase counter ph SHALL advance 0..SYMBOL_LEN-1 every cycle in SEARCH and TRACK and wrap to 0.
REQ-023 SEARCH: on every cycle where m > best_mag (strict comparison), the block SHALL set best_mag=m and best_ph=ph, so the earliest phase wins a tie.
REQ-024 SEARCH end: after SEARCH_SYMS complete periods, the block SHALL go to TRACK with phase_idx=best_ph if best_mag >= MIN_MAG.
REQ-025 SEARCH end: otherwise the block SHALL clear best_mag, stay in SEARCH and start a new window.
REQ-026 TRACK: on each cycle with ph==phase_idx, the block SHALL register bit_out = (sin_corr >= CORR_BIAS) and pulse valid for exactly one cycle, the cycle after sampling.
REQ-027 TRACK: a decision with m < MIN_MAG SHALL increment the weak counter, and one with m >= MIN_MAG SHALL clear it.
REQ-028 TRACK: when the weak counter reaches LOSS_CNT, the block SHALL go to SEARCH with best_mag cleared; no valid pulse SHALL be issued for that decision.
REQ-029 locked SHALL be 1 exactly while in TRACK.
REQ-030 valid SHALL never be high outside TRACK, and two valid pulses SHALL be separated by exactly SYMBOL_LEN cycles while lock is held.
REQ-031 When en falls on a sampling cycle, no valid SHALL follow.

Reset
REQ-032 On rst=1 the block SHALL set state=IDLE, bit_out=0, valid=0, locked=0, phase_idx=0, and clear all counters, best_mag and best_ph.
REQ-033 rst SHALL take priority over en and abort any state mid-operation; the block SHALL restart from IDLE with FILL repeated.

Structure
REQ-034 A shared package demod_pkg SHALL hold SYMBOL_LEN, CORR_W, PIPE_LAT and the state enumeration for reuse by demodulator-side blocks.
REQ-035 The metric SHALL be a combinational sub-module corr_mag that takes sin_corr, cos_corr and CORR_BIAS and returns m and the sign of s.
REQ-036 All state, counters and outputs SHALL live in demod_symbol_ctrl.

Verification
REQ-037 Apply rst for 2 cycles, then en=1 with sin_corr=cos_corr=CORR_BIAS constant -> locked stays 0, valid never asserts, and SEARCH restarts every 128 cycles.
REQ-038 Hold en=1 after FILL; drive sin_corr=CORR_BIAS+24'h8000 only at ph=13 and CORR_BIAS elsewhere -> locked rises 128 cycles after SEARCH entry, phase_idx=13, and valid repeats every 32 cycles with bit_out=1.
REQ-039 Once locked, drive sin_corr=CORR_BIAS-24'h8000 at phase 13 -> bit_out=0 on the next strobe.
REQ-040 Drive equal peaks at ph=7 and ph=20 -> phase_idx=7.
REQ-041 Once locked, drop the signal to the bias level -> exactly 7 valid pulses, then locked=0 at the 8th weak decision, with no 8th pulse.
REQ-042 Assert rst, or deassert en, during TRACK -> next cycle valid=0, locked=0 and state IDLE; re-enabling -> lock returns no earlier than 37+128 cycles later.
